game_round_controller: RTL and testbench
========================================

GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 Parameter WIN_SCORE, default 3, meaning the hit count that ends the match (legal range 1..15).
REQ-002 Parameter HOLD_FRAMES, default 120, meaning the number of Clk cycles the field stays frozen after a scoring hit (legal range 1..1023).
REQ-003 Clk  input  1  frame clock (VGA_VS); all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 nextStateSig  input  1  level from the active-high KEY[1] button; only rising edges are acted on.
REQ-006 hit_A  input  1  bullet A overlaps tank B this cycle (level).
REQ-007 hit_B  input  1  bullet B overlaps tank A this cycle (level).
REQ-008 currentState  output  2  game phase for color_mapper/selectors: 0 TITLE, 1 SELECT, 2 PLAY, 3 OVER.
REQ-009 freeze  output  1  1 while tanks and bullets shall hold position.
REQ-010 respawn  output  1  single-cycle pulse to return tanks and bullets to start positions.
REQ-011 scoreA, scoreB  output  4 each  hits scored by player A and player B.
REQ-012 winner  output  2  00 none, 01 A, 10 B; 11 is never driven.

Function
REQ-013 Edge detect: press = nextStateSig & ~prev, where prev is nextStateSig registered on the previous cycle.
REQ-014 Internal states: TITLE, SELECT, PLAY, HOLD, OVER; currentState encodes HOLD as 2.
REQ-015 freeze = 1 in every state except PLAY.
REQ-016 TITLE: press -> SELECT. All other inputs are ignored.
REQ-017 SELECT: press -> PLAY; in the same cycle, scoreA, scoreB and winner are cleared and respawn = 1 for one cycle.
REQ-018 PLAY: nextStateSig is ignored. Hits are evaluated in the priority order of REQ-019..REQ-021.
REQ-019 PLAY, hit_A & hit_B in the same cycle: treated as a draw; no score change; -> HOLD.
REQ-020 PLAY, hit_A only: scoreA increments by 1. If the new value equals WIN_SCORE -> OVER with winner = 01; otherwise -> HOLD.
REQ-021 PLAY, hit_B only: symmetric to REQ-020, affecting scoreB; a win sets winner = 10.
REQ-022 HOLD entry loads hold counter = HOLD_FRAMES-1; the counter decrements once per cycle.
REQ-023 HOLD, counter = 0: respawn pulses for one cycle and the state returns to PLAY. HOLD therefore lasts exactly HOLD_FRAMES cycles.
REQ-024 HOLD ignores hit_A, hit_B and press. Hit levels that persist into HOLD shall not score again.
REQ-025 On return to PLAY, a hit already asserted in the first PLAY cycle does score.
REQ-026 OVER: scores and winner are held. press -> TITLE; scores and winner persist until the next SELECT->PLAY transition.
REQ-027 Score arithmetic is 4-bit unsigned. Scores cannot exceed WIN_SCORE, so no wrap occurs.
REQ-028 All outputs are registered; a state change is visible on outputs the cycle after the triggering input is sampled.

Reset
REQ-029 Reset takes priority over all inputs in any state, including mid-HOLD.
REQ-030 Reset values: state TITLE, currentState 0, freeze 1, respawn 0, scoreA 0, scoreB 0, winner 00, hold counter 0.
REQ-031 During Reset, prev is loaded with 1, so a button held through reset release produces no press.

Verification
REQ-032 Reset, then pulse nextStateSig twice (low between pulses) -> currentState 0->1->2; respawn high exactly one cycle on entering PLAY; freeze 0.
REQ-033 In PLAY, assert hit_A for 5 cycles -> scoreA=1 (not 5); freeze=1 for 120 cycles; respawn pulse; currentState=2 and freeze=0 on the following cycle.
REQ-034 In PLAY, assert hit_A and hit_B in the same cycle -> scores unchanged; HOLD entered; PLAY resumes after 120 cycles.
REQ-035 With WIN_SCORE=3, land three hit_B events, each separated by a HOLD -> after the third, currentState=3, winner=10, scoreB=3; a press then -> currentState=0 with scoreB still 3; SELECT->PLAY clears scores.
REQ-036 Assert Reset at HOLD counter=50 -> next cycle all outputs at reset values; nextStateSig held high across reset release -> no transition until it is released and pressed again.

Source files
------------

// File: rtl/game_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : game_round_controller
// Description : Match sequencer for a two-tank game. Walks TITLE -> SELECT ->
//               PLAY, freezes the field for HOLD_FRAMES frames after every
//               scoring hit, tracks both scores and declares a winner once a
//               player reaches WIN_SCORE.
// Ports       : Clk          frame clock, all state changes on rising edge
//               Reset        synchronous active-high reset
//               nextStateSig button level, only rising edges are acted on
//               hit_A/hit_B  bullet A hits tank B / bullet B hits tank A
//               currentState 0 TITLE, 1 SELECT, 2 PLAY (also HOLD), 3 OVER
//               freeze       hold tanks and bullets in place
//               respawn      one-cycle pulse to return objects to start
//               scoreA/B     hit counts, winner 00 none, 01 A, 10 B
// Revision    : 1.0 - initial release
// ============================================================================
module game_round_controller #(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       nextStateSig,
    input  logic       hit_A,
    input  logic       hit_B,
    output logic [1:0] currentState,
    output logic       freeze,
    output logic       respawn,
    output logic [3:0] scoreA,
    output logic [3:0] scoreB,
    output logic [1:0] winner
);

    localparam logic [2:0] c_S_TITLE  = 3'd0;
    localparam logic [2:0] c_S_SELECT = 3'd1;
    localparam logic [2:0] c_S_PLAY   = 3'd2;
    localparam logic [2:0] c_S_HOLD   = 3'd3;
    localparam logic [2:0] c_S_OVER   = 3'd4;

    localparam logic [1:0] c_PH_TITLE  = 2'd0;
    localparam logic [1:0] c_PH_SELECT = 2'd1;
    localparam logic [1:0] c_PH_PLAY   = 2'd2;
    localparam logic [1:0] c_PH_OVER   = 2'd3;

    localparam logic [1:0] c_WIN_NONE = 2'b00;
    localparam logic [1:0] c_WIN_A    = 2'b01;
    localparam logic [1:0] c_WIN_B    = 2'b10;

    localparam logic [3:0] c_WIN_SCORE = 4'(WIN_SCORE);
    localparam logic [9:0] c_HOLD_LOAD = 10'(HOLD_FRAMES - 1);

    logic [2:0] r_state;
    logic [9:0] r_hold_cnt;
    logic       r_prev;
    logic       w_press;
    logic [3:0] w_score_a_inc;
    logic [3:0] w_score_b_inc;

    assign w_press       = nextStateSig & ~r_prev;
    assign w_score_a_inc = scoreA + 4'd1;
    assign w_score_b_inc = scoreB + 4'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= c_S_TITLE;
            r_hold_cnt   <= 10'd0;
            // Loaded high so a button held through reset release is not a press.
            r_prev       <= 1'b1;
            currentState <= c_PH_TITLE;
            freeze       <= 1'b1;
            respawn      <= 1'b0;
            scoreA       <= 4'd0;
            scoreB       <= 4'd0;
            winner       <= c_WIN_NONE;
        end else begin
            r_prev  <= nextStateSig;
            respawn <= 1'b0;
            case (r_state)
                c_S_TITLE: begin
                    if (w_press) begin
                        r_state      <= c_S_SELECT;
                        currentState <= c_PH_SELECT;
                    end
                end
                c_S_SELECT: begin
                    if (w_press) begin
                        r_state      <= c_S_PLAY;
                        currentState <= c_PH_PLAY;
                        freeze       <= 1'b0;
                        respawn      <= 1'b1;
                        scoreA       <= 4'd0;
                        scoreB       <= 4'd0;
                        winner       <= c_WIN_NONE;
                    end
                end
                c_S_PLAY: begin
                    // A simultaneous hit is a draw: freeze without scoring.
                    if (hit_A && hit_B) begin
                        r_state    <= c_S_HOLD;
                        r_hold_cnt <= c_HOLD_LOAD;
                        freeze     <= 1'b1;
                    end else if (hit_A) begin
                        scoreA <= w_score_a_inc;
                        freeze <= 1'b1;
                        if (w_score_a_inc == c_WIN_SCORE) begin
                            r_state      <= c_S_OVER;
                            currentState <= c_PH_OVER;
                            winner       <= c_WIN_A;
                        end else begin
                            r_state    <= c_S_HOLD;
                            r_hold_cnt <= c_HOLD_LOAD;
                        end
                    end else if (hit_B) begin
                        scoreB <= w_score_b_inc;
                        freeze <= 1'b1;
                        if (w_score_b_inc == c_WIN_SCORE) begin
                            r_state      <= c_S_OVER;
                            currentState <= c_PH_OVER;
                            winner       <= c_WIN_B;
                        end else begin
                            r_state    <= c_S_HOLD;
                            r_hold_cnt <= c_HOLD_LOAD;
                        end
                    end
                end
                c_S_HOLD: begin
                    // Counter runs HOLD_FRAMES-1 down to 0, one frame each.
                    if (r_hold_cnt == 10'd0) begin
                        r_state <= c_S_PLAY;
                        freeze  <= 1'b0;
                        respawn <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 10'd1;
                    end
                end
                c_S_OVER: begin
                    // Scores and winner stay visible until the next match starts.
                    if (w_press) begin
                        r_state      <= c_S_TITLE;
                        currentState <= c_PH_TITLE;
                    end
                end
                default: begin
                    r_state      <= c_S_TITLE;
                    currentState <= c_PH_TITLE;
                    freeze       <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_round_controller
// Description : Self-checking bench for game_round_controller. Stimulus
//               drives directed match scenarios followed by random play and
//               pushes the predicted outputs into a queue; a monitor pops and
//               compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_controller;

    localparam int WIN_SCORE   = 3;
    localparam int HOLD_FRAMES = 120;

    logic       clk;
    logic       rst;
    logic       nss;
    logic       hit_a;
    logic       hit_b;
    logic [1:0] current_state;
    logic       freeze;
    logic       respawn;
    logic [3:0] score_a;
    logic [3:0] score_b;
    logic [1:0] winner;

    game_round_controller #(
        .WIN_SCORE  (WIN_SCORE),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .nextStateSig(nss),
        .hit_A       (hit_a),
        .hit_B       (hit_b),
        .currentState(current_state),
        .freeze      (freeze),
        .respawn     (respawn),
        .scoreA      (score_a),
        .scoreB      (score_b),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [13:0] exp_q[$];

    // Reference model: phase names plus "frames of freeze still to serve".
    int m_phase;      // 0 TITLE, 1 SELECT, 2 PLAY, 3 HOLD, 4 OVER
    int m_left;
    int m_sa;
    int m_sb;
    int m_win;
    bit m_prev;
    bit m_respawn;

    function automatic logic [13:0] model_outputs();
        logic [1:0] cs;
        logic       frz;
        if (m_phase == 3)      cs = 2'd2;
        else if (m_phase == 4) cs = 2'd3;
        else                   cs = 2'(m_phase);
        frz = (m_phase != 2);
        return {cs, frz, m_respawn, 4'(m_sa), 4'(m_sb), 2'(m_win)};
    endfunction

    task automatic model_step(input bit r, input bit n, input bit a, input bit b);
        bit press;
        if (r) begin
            m_phase = 0; m_left = 0; m_sa = 0; m_sb = 0; m_win = 0;
            m_prev = 1'b1; m_respawn = 1'b0;
            return;
        end
        press     = n && !m_prev;
        m_prev    = n;
        m_respawn = 1'b0;
        case (m_phase)
            0: if (press) m_phase = 1;
            1: if (press) begin
                   m_phase = 2; m_sa = 0; m_sb = 0; m_win = 0; m_respawn = 1'b1;
               end
            2: begin
                   if (a && b) begin
                       m_phase = 3; m_left = HOLD_FRAMES;
                   end else if (a || b) begin
                       if (a) m_sa++; else m_sb++;
                       if (m_sa == WIN_SCORE || m_sb == WIN_SCORE) begin
                           m_phase = 4; m_win = a ? 1 : 2;
                       end else begin
                           m_phase = 3; m_left = HOLD_FRAMES;
                       end
                   end
               end
            3: begin
                   m_left--;
                   if (m_left == 0) begin
                       m_phase = 2; m_respawn = 1'b1;
                   end
               end
            default: if (press) m_phase = 0;
        endcase
    endtask

    // One frame: drive inputs, predict outputs after the next edge, queue them.
    task automatic step(input bit r, input bit n, input bit a, input bit b);
        logic [13:0] e;
        rst = r; nss = n; hit_a = a; hit_b = b;
        model_step(r, n, a, b);
        e = model_outputs();
        @(posedge clk);
        exp_q.push_back(e);
        cycle++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_btn();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every registered output once per frame.
    initial begin
        logic [13:0] act;
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {current_state, freeze, respawn, score_a, score_b, winner};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got state=%0d frz=%0b rsp=%0b A=%0d B=%0d win=%0d expected state=%0d frz=%0b rsp=%0b A=%0d B=%0d win=%0d",
                             cycle, act[13:12], act[11], act[10], act[9:6], act[5:2], act[1:0],
                             e[13:12], e[11], e[10], e[9:6], e[5:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        bit n;
        rst = 1'b1; nss = 1'b0; hit_a = 1'b0; hit_b = 1'b0;
        m_phase = 0; m_left = 0; m_sa = 0; m_sb = 0; m_win = 0;
        m_prev = 1'b1; m_respawn = 1'b0;

        // Reset, then two presses into PLAY.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        press_btn();
        idle(2);
        press_btn();
        idle(4);

        // Held hit scores once, then a full freeze period.
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(HOLD_FRAMES + 5);

        // Draw.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(HOLD_FRAMES + 5);

        // Three hits for B, the last one wins.
        for (int k = 0; k < WIN_SCORE; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(HOLD_FRAMES + 3);
        end
        press_btn();
        idle(3);
        press_btn();
        press_btn();
        idle(3);

        // Reset in the middle of a freeze with the button held across release.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(HOLD_FRAMES - 51);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        press_btn();
        press_btn();
        idle(2);

        // Random play with occasional resets and button activity in every phase.
        n = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 7) == 0) n = ~n;
            step($urandom_range(0, 1499) == 0, n,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
